// File: rtl/ctr_pkg.sv
// Shared encodings for the multi-cycle controller: instruction fields,
// FSM states and datapath select codes.
package ctr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_RTYPE_WB, S_ADDI_EX, S_ADDI_WB, S_BEQ, S_JUMP, S_ILLEGAL
  } state_t;

  function automatic logic funct_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/ctr_decode.sv
// Maps OpCode/Funct to the state following DECODE, plus an illegal flag
// for unsupported opcodes and R-type functs.
module ctr_decode
  import ctr_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic [OP_W-1:0] OpCode,
  input  logic [FN_W-1:0] Funct,
  output state_t          nxt,
  output logic            illegal
);

  logic [5:0] op6, fn6;
  assign op6 = 6'(OpCode);
  assign fn6 = 6'(Funct);

  always_comb begin
    nxt     = S_ILLEGAL;
    illegal = 1'b1;
    case (op6)
      OP_LW, OP_SW: begin nxt = S_MEMADR;  illegal = 1'b0; end
      OP_ADDI:      begin nxt = S_ADDI_EX; illegal = 1'b0; end
      OP_BEQ:       begin nxt = S_BEQ;     illegal = 1'b0; end
      OP_J:         begin nxt = S_JUMP;    illegal = 1'b0; end
      OP_RTYPE:
        if (funct_ok(fn6)) begin
          nxt     = S_RTYPE_EX;
          illegal = 1'b0;
        end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctr.sv
// Moore control FSM for a multi-cycle MIPS-style datapath with a
// retired-fetch counter; outputs depend only on state and MemReady.
module multi_cycle_ctr
  import ctr_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int FN_W   = 6,
  parameter int CNT_W  = 32,
  parameter int MEM_HS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  OpCode,
  input  logic [FN_W-1:0]  Funct,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  state_t     state, dec_nxt;
  logic       dec_ill, mem_rdy;
  logic [5:0] op6;

  assign mem_rdy = (MEM_HS != 0) ? MemReady : 1'b1;
  assign op6     = 6'(OpCode);

  ctr_decode #(.OP_W(OP_W), .FN_W(FN_W)) u_dec (
    .OpCode (OpCode),
    .Funct  (Funct),
    .nxt    (dec_nxt),
    .illegal(dec_ill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else begin
      case (state)
        S_IDLE:     state <= S_FETCH;
        S_FETCH:    if (mem_rdy) state <= S_DECODE;
        S_DECODE:   state <= dec_ill ? S_ILLEGAL : dec_nxt;
        S_MEMADR:   state <= (op6 == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:    if (mem_rdy) state <= S_MEMWB;
        S_MEMWR:    if (mem_rdy) state <= S_FETCH;
        S_RTYPE_EX: state <= S_RTYPE_WB;
        S_ADDI_EX:  state <= S_ADDI_WB;
        S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_JUMP, S_ILLEGAL:
                    state <= S_FETCH;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Counts IR loads, so a stalled fetch is counted once, when it completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        InstrCount <= '0;
    else if (IRWrite) InstrCount <= InstrCount + CNT_W'(1);
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    Illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
      end
      S_DECODE:   ALUSrcB = SRCB_IMM_SH;
      S_MEMADR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDI_WB:  RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ILLEGAL:  Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Scoreboard bench: an instruction-level model emits per-cycle expected
// controls; a driver issues stimulus and a monitor checks each cycle.
module tb_multi_cycle_ctr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] op; logic [5:0] fn; logic mr; } stim_t;
  typedef struct packed { logic [16:0] v; logic [3:0] c; } exp_t;

  logic       rst, rst1;
  logic [5:0] OpCode, Funct, op1;
  logic       MemReady;

  logic       pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, ill;
  logic [1:0] asb, aop, psrc;
  logic [3:0] cnt;
  logic       pcw1, pcwc1, iord1, irw1, mrd1, mwr1, m2r1, rdst1, rw1, asa1, ill1;
  logic [1:0] asb1, aop1, psrc1;
  logic [31:0] cnt1;

  wire [16:0] act  = {pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, asb, aop, psrc, ill};
  wire [16:0] act1 = {pcw1, pcwc1, iord1, irw1, mrd1, mwr1, m2r1, rdst1, rw1, asa1, asb1, aop1, psrc1, ill1};

  multi_cycle_ctr #(.OP_W(6), .FN_W(6), .CNT_W(4), .MEM_HS(1)) u0 (
    .clk(clk), .reset(rst), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .IRWrite(irw), .MemRead(mrd),
    .MemWrite(mwr), .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(asa),
    .ALUSrcB(asb), .ALUOp(aop), .PCSource(psrc), .Illegal(ill), .InstrCount(cnt)
  );

  multi_cycle_ctr #(.OP_W(6), .FN_W(6), .CNT_W(32), .MEM_HS(0)) u1 (
    .clk(clk), .reset(rst1), .OpCode(op1), .Funct(6'b000000), .MemReady(1'b0),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .IRWrite(irw1), .MemRead(mrd1),
    .MemWrite(mwr1), .MemtoReg(m2r1), .RegDst(rdst1), .RegWrite(rw1), .ALUSrcA(asa1),
    .ALUSrcB(asb1), .ALUOp(aop1), .PCSource(psrc1), .Illegal(ill1), .InstrCount(cnt1)
  );

  int total = 0, bad = 0, ecnt = 0;
  bit drv_done = 0;
  stim_t gen_s[$];
  exp_t  gen_e[$];
  exp_t  sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Argument order matches the packing of act.
  function automatic logic [16:0] mk(input logic a_pcw, a_pcwc, a_iord, a_irw, a_mrd,
      a_mwr, a_m2r, a_rdst, a_rw, a_asa, input logic [1:0] a_asb, a_aop, a_psrc,
      input logic a_ill);
    return {a_pcw, a_pcwc, a_iord, a_irw, a_mrd, a_mwr, a_m2r, a_rdst, a_rw, a_asa,
            a_asb, a_aop, a_psrc, a_ill};
  endfunction

  function automatic logic [16:0] v_fetch(input logic r);
    return mk(r,0,0,r,1,0,0,0,0,0, 2'b01,2'b00,2'b00, 0);
  endfunction
  function automatic logic [16:0] v_dec();    return mk(0,0,0,0,0,0,0,0,0,0, 2'b11,2'b00,2'b00,0); endfunction
  function automatic logic [16:0] v_madr();   return mk(0,0,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00,0); endfunction
  function automatic logic [16:0] v_mrd();    return mk(0,0,1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,0); endfunction
  function automatic logic [16:0] v_mwb();    return mk(0,0,0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,0); endfunction
  function automatic logic [16:0] v_mwr();    return mk(0,0,1,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,0); endfunction
  function automatic logic [16:0] v_rex();    return mk(0,0,0,0,0,0,0,0,0,1, 2'b00,2'b10,2'b00,0); endfunction
  function automatic logic [16:0] v_rwb();    return mk(0,0,0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00,0); endfunction
  function automatic logic [16:0] v_aex();    return mk(0,0,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00,0); endfunction
  function automatic logic [16:0] v_awb();    return mk(0,0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,0); endfunction
  function automatic logic [16:0] v_beq();    return mk(0,1,0,0,0,0,0,0,0,1, 2'b00,2'b01,2'b01,0); endfunction
  function automatic logic [16:0] v_jmp();    return mk(1,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10,0); endfunction
  function automatic logic [16:0] v_ill();    return mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,1); endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic int nwait();
    return ($urandom_range(0, 3) == 3) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic cyc(input logic [16:0] v, input logic [5:0] op, fn, input logic mr);
    stim_t s;
    exp_t  e;
    s.op = op; s.fn = fn; s.mr = mr;
    e.v = v;   e.c = 4'(ecnt % 16);
    gen_s.push_back(s);
    gen_e.push_back(e);
  endtask

  // kind: 0 lw, 1 sw, 2 R-type, 3 bad funct, 4 addi, 5 beq, 6 j, 7 bad opcode
  task automatic gen_instr(input int kind);
    logic [5:0] op, fn;
    int w;
    fn = 6'($urandom_range(0, 63));
    case (kind)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: begin
        op = 6'b000000;
        case ($urandom_range(0, 4))
          0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
          3: fn = 6'b100101; default: fn = 6'b101010;
        endcase
      end
      3: begin
        op = 6'b000000;
        while (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
          fn = 6'($urandom_range(0, 63));
      end
      4: op = 6'b001000;
      5: op = 6'b000100;
      6: op = 6'b000010;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010})
          op = 6'($urandom_range(0, 63));
      end
    endcase
    w = nwait();
    for (int i = 0; i < w; i++) cyc(v_fetch(0), op, fn, 0);
    cyc(v_fetch(1), op, fn, 1);
    ecnt++;
    cyc(v_dec(), op, fn, rb());
    case (kind)
      0: begin
        cyc(v_madr(), op, fn, rb());
        w = nwait();
        for (int i = 0; i < w; i++) cyc(v_mrd(), op, fn, 0);
        cyc(v_mrd(), op, fn, 1);
        cyc(v_mwb(), op, fn, rb());
      end
      1: begin
        cyc(v_madr(), op, fn, rb());
        w = nwait();
        for (int i = 0; i < w; i++) cyc(v_mwr(), op, fn, 0);
        cyc(v_mwr(), op, fn, 1);
      end
      2: begin cyc(v_rex(), op, fn, rb()); cyc(v_rwb(), op, fn, rb()); end
      4: begin cyc(v_aex(), op, fn, rb()); cyc(v_awb(), op, fn, rb()); end
      5: cyc(v_beq(), op, fn, rb());
      6: cyc(v_jmp(), op, fn, rb());
      default: cyc(v_ill(), op, fn, rb());
    endcase
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; OpCode = '0; Funct = '0; MemReady = 1'b0; op1 = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_ctl", 32'(act), 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);

    // MemReady ignored when MEM_HS=0: beq runs in 3 cycles with MemReady tied low
    @(posedge clk); #1; rst1 = 1'b0; op1 = 6'b000100;
    #2; chk("hs0_idle", 32'(act1), 32'd0);
    @(posedge clk); #2; chk("hs0_fetch", 32'(act1), 32'(v_fetch(1)));
    chk("hs0_cnt0", cnt1, 32'd0);
    @(posedge clk); #2; chk("hs0_decode", 32'(act1), 32'(v_dec()));
    chk("hs0_cnt1", cnt1, 32'd1);
    @(posedge clk); #2; chk("hs0_beq", 32'(act1), 32'(v_beq()));
    @(posedge clk); #2; chk("hs0_refetch", 32'(act1), 32'(v_fetch(1)));
    chk("reset_hold_ctl", 32'(act), 32'd0);
    chk("reset_hold_cnt", 32'(cnt), 32'd0);

    // Model: IDLE, sixteen jumps (counter wraps), then a random mix.
    cyc(17'd0, 6'b000010, 6'd0, rb());
    for (int i = 0; i < 16; i++) gen_instr(6);
    gen_instr(2);
    gen_instr(0);
    gen_instr(7);
    gen_instr(3);
    for (int i = 0; i < 60; i++) gen_instr(int'($urandom_range(0, 7)));

    fork
      begin : driver
        stim_t s;
        bit first = 1;
        while (gen_s.size() != 0) begin
          @(posedge clk); #1;
          s = gen_s.pop_front();
          if (first) rst = 1'b0;
          first = 0;
          OpCode = s.op; Funct = s.fn; MemReady = s.mr;
          sb.push_back(gen_e.pop_front());
        end
        drv_done = 1;
      end
      begin : monitor
        exp_t e;
        int guard = 0;
        while (!(drv_done && sb.size() == 0)) begin
          @(negedge clk);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ctl", 32'(act), 32'(e.v));
            chk("cnt", 32'(cnt), 32'(e.c));
          end
          guard++;
          if (guard > 5000) begin
            bad++;
            $display("FAIL monitor_timeout: got %0d pending want 0", sb.size());
            break;
          end
        end
      end
    join

    // Asynchronous reset in the middle of a stalled store.
    @(posedge clk); #1; rst = 1'b1; OpCode = 6'b101011; MemReady = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1; MemReady = 1'b0;
    @(posedge clk); #1; chk("sw_wait1", 32'(act), 32'(v_mwr()));
    @(posedge clk); #1; chk("sw_wait2", 32'(act), 32'(v_mwr()));
    #3; rst = 1'b1;
    #1; chk("async_mwr", 32'(mwr), 32'd0);
    chk("async_ctl", 32'(act), 32'd0);
    chk("async_cnt", 32'(cnt), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    #2; chk("post_idle", 32'(act), 32'd0);
    chk("post_cnt", 32'(cnt), 32'd0);
    @(posedge clk); #2; chk("post_fetch", 32'(act), 32'(v_fetch(0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctr.md
MULTI_CYCLE_CTR -- requirements
Module: multi_cycle_ctr

Interface
REQ-001 Parameter OP_W, default 6: OpCode width.
REQ-002 Parameter FN_W, default 6: Funct width.
REQ-003 Parameter CNT_W, default 32: retired-instruction counter width.
REQ-004 Parameter MEM_HS, default 1: 1 = honour MemReady; 0 = MemReady treated as constant 1.
REQ-005 clk  input  1  single clock, all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 OpCode  input  OP_W  instruction bits [31:26], sampled from IR.
REQ-008 Funct  input  FN_W  instruction bits [5:0], sampled from IR.
REQ-009 MemReady  input  1  memory completes the current access this cycle.
REQ-010 PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  standard multi-cycle datapath controls.
REQ-011 ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-012 ALUOp  output  2  00 = add, 01 = sub, 10 = use Funct.
REQ-013 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 Illegal  output  1  one-cycle pulse on an unsupported OpCode or R-type Funct.
REQ-015 InstrCount  output  CNT_W  count of completed instruction fetches.

Function
REQ-016 Moore FSM; all control outputs SHALL be decoded from the state register and MemReady only.
REQ-017 States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, ADDI_EX, ADDI_WB, BEQ, JUMP, ILLEGAL.
REQ-018 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-019 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=MemReady; advance to DECODE only when MemReady=1, else hold.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by OpCode: 100011/101011 -> MEMADR, 000000 -> RTYPE_EX, 001000 -> ADDI_EX, 000100 -> BEQ, 000010 -> JUMP, any other -> ILLEGAL.
REQ-021 RTYPE_EX is entered only for Funct in {100000, 100010, 100100, 100101, 101010}; any other Funct with OpCode 000000 -> ILLEGAL.
REQ-022 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next is MEMRD for lw, MEMWR for sw.
REQ-023 MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then MEMWB.
REQ-024 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-025 MEMWR: MemWrite=1, IorD=1; hold until MemReady=1, then FETCH.
REQ-026 RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RTYPE_WB.
REQ-027 RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-028 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDI_WB.
REQ-029 ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-030 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-031 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-032 ILLEGAL: Illegal=1 and all other outputs 0 for exactly one cycle; next FETCH; the PC is not rewritten.
REQ-033 MemRead and MemWrite SHALL remain asserted, with unchanged IorD, on every cycle of a MemReady wait.
REQ-034 InstrCount SHALL increment by 1 on each cycle with IRWrite=1 and wrap from 2^CNT_W-1 to 0.
REQ-035 Latencies with MemReady=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3 cycles.

Reset
REQ-036 While reset=1, the state SHALL be IDLE, all outputs SHALL be 0 and InstrCount SHALL be 0, regardless of clk.
REQ-037 Reset asserted mid-instruction, including during a MemReady wait, SHALL abort the instruction immediately with no further strobe.

Structure
REQ-038 OpCode/Funct encodings, state encoding, and ALUSrcB/ALUOp/PCSource encodings SHALL live in a shared package, ctr_pkg.
REQ-039 One sub-module, ctr_decode, SHALL map OpCode/Funct to the DECODE next-state and the illegal flag.

Verification
REQ-040 Release reset, OpCode=000000, Funct=100000, MemReady=1 -> states IDLE, FETCH, DECODE, RTYPE_EX, RTYPE_WB; RegWrite=1 and RegDst=1 in cycle 5; InstrCount=1.
REQ-041 Issue lw (100011) with MemReady low for 3 cycles in MEMRD -> MemRead=1 and IorD=1 held for 4 cycles, then MEMWB with RegWrite=1 and MemtoReg=1.
REQ-042 OpCode=111111 -> Illegal pulses exactly 1 cycle; then FETCH; then OpCode=000000 with Funct=000001 -> Illegal pulses again.
REQ-043 CNT_W=4: run 16 j (000010) instructions -> InstrCount returns to 0; PCWrite=1 with PCSource=10 in each JUMP state.
REQ-044 Assert reset asynchronously mid-MEMWR -> MemWrite drops to 0 before the next clk edge; after release the state is IDLE and InstrCount=0.
REQ-045 MEM_HS=0 with MemReady tied to 0: beq (000100) -> completes in 3 cycles with PCWriteCond=1, ALUOp=01.
